urf_port_arbiter: RTL

- Shares the single write port and single read port of the universal register file (URF) between NUM_REQ requesters.
- Round-robin arbitration grants at most one transaction (read or write) per cycle.
- Drives registered URF control signals.
- Returns read data tagged with the requester ID.
- Sits between the requesting masters and the URF instance.

---
 rtl/urf_port_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/urf_port_arbiter.sv
// urf_port_arbiter: round-robin sharing of the URF write/read ports between NUM_REQ requesters,
// with registered URF controls and ID-tagged read responses two cycles after the grant.
module urf_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_we,
    output logic [ADDR_WIDTH-1:0]          rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           rf_re,
    output logic [ADDR_WIDTH-1:0]          rf_raddr,
    input  logic [DATA_WIDTH-1:0]          rf_rdata,
    output logic                           rsp_valid,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err
);
    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_re;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_p1_v, r_p2_v;
    logic [ID_WIDTH-1:0]   r_p1_id, r_p2_id;
    logic                  r_p1_err, r_p2_err;
    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_gid;
    logic [ID_WIDTH-1:0]   w_nptr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_ok;
    logic                  w_wr;
    logic                  w_rd;
    // Walking the offsets downward lets the lowest offset from r_ptr win.
    always_comb begin
        w_any = 1'b0;
        w_gid = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_any = 1'b1;
                w_gid = ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end
    assign req_ready = w_any ? (NUM_REQ'(1) << w_gid) : '0;
    assign w_nptr    = (w_gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
    assign w_addr    = req_addr[w_gid*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata   = req_wdata[w_gid*DATA_WIDTH +: DATA_WIDTH];
    assign w_ok      = int'(w_addr) < DEPTH;
    assign w_wr      = w_any & req_we[w_gid];
    assign w_rd      = w_any & ~req_we[w_gid];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_re     <= 1'b0;
            r_raddr  <= '0;
            r_p1_v   <= 1'b0;
            r_p1_id  <= '0;
            r_p1_err <= 1'b0;
            r_p2_v   <= 1'b0;
            r_p2_id  <= '0;
            r_p2_err <= 1'b0;
        end else begin
            if (w_any)
                r_ptr <= w_nptr;
            r_we     <= w_wr & w_ok;
            r_waddr  <= (w_wr & w_ok) ? w_addr : '0;
            r_wdata  <= (w_wr & w_ok) ? w_wdata : '0;
            r_re     <= w_rd & w_ok;
            r_raddr  <= (w_rd & w_ok) ? w_addr : '0;
            r_p1_v   <= w_rd;
            r_p1_id  <= w_rd ? w_gid : '0;
            r_p1_err <= w_rd & ~w_ok;
            r_p2_v   <= r_p1_v;
            r_p2_id  <= r_p1_id;
            r_p2_err <= r_p1_err;
        end
    end
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign rf_re     = r_re;
    assign rf_raddr  = r_raddr;
    assign rsp_valid = r_p2_v;
    assign rsp_id    = r_p2_id;
    assign rsp_err   = r_p2_err;
    assign rsp_rdata = (r_p2_v & ~r_p2_err) ? rf_rdata : '0;
endmodule
